// File: rtl/dcnn_pkg.sv
// dcnn_pkg: definitions shared by the image DMA writer and the row fetcher.
// Holds the row/block geometry defaults, so both sides pack and unpack rows
// identically, and the state encoding of the row fetch FSM.
package dcnn_pkg;

  localparam int ROW_SIZE   = 16;  // assembled row width in bits
  localparam int BLOCK_SIZE = 4;   // RAM word width in bits
  localparam int ADDR_WIDTH = 16;  // RAM address width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    VALID = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/row_fetch_if.sv
// row_fetch_if: read/write port of the shared image RAM.
//   ram_enable   request strobe        (master -> slave)
//   ram_write    write select          (master -> slave)
//   ram_address  word address          (master -> slave)
//   ram_data     read data, valid the cycle after a request (slave -> master)
interface row_fetch_if
  import dcnn_pkg::*;
#(
  parameter int addrWidth = ADDR_WIDTH,
  parameter int blockSize = BLOCK_SIZE
);

  logic                 ram_enable;
  logic                 ram_write;
  logic [addrWidth-1:0] ram_address;
  logic [blockSize-1:0] ram_data;

  modport master (output ram_enable, output ram_write, output ram_address, input ram_data);
  modport slave  (input ram_enable, input ram_write, input ram_address, output ram_data);

endinterface

// File: rtl/row_pack_shift.sv
// row_pack_shift: slot register that assembles a row from RAM blocks.
//   clk   clock
//   clr   synchronous clear of every slot
//   load  write din into slot idx this edge
//   idx   slot index; slot 0 is the least-significant block of row
//   din   block data
//   row   all slots, concatenated
// Unloaded slots keep their previous contents.
module row_pack_shift #(
  parameter int blockSize = 4,
  parameter int slots     = 4,
  parameter int idxWidth  = 2
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       load,
  input  logic [idxWidth-1:0]        idx,
  input  logic [blockSize-1:0]       din,
  output logic [slots*blockSize-1:0] row
);

  logic [slots-1:0][blockSize-1:0] row_q;
  logic [slots-1:0][blockSize-1:0] row_d;

  always_comb begin
    row_d = row_q;
    if (load) row_d[idx] = din;
  end

  always_ff @(posedge clk) begin
    if (clr) row_q <= '0;
    else     row_q <= row_d;
  end

  assign row = row_q;

endmodule

// File: rtl/row_fetch.sv
// row_fetch: reads rowSize/blockSize consecutive RAM words starting at
// start_address and reassembles them into one row (lowest address in the
// least-significant block), then offers the row on a valid/ready handshake.
//   clk, rst       clock, synchronous active-high reset
//   start          fetch request, accepted only while busy=0
//   start_address  address of block 0, sampled with an accepted start
//   busy           high from the accepting edge until handoff
//   ram            RAM master port (read-only use)
//   row_out        assembled row, qualified by row_valid
//   row_valid      row complete; held until row_ready
//   row_ready      consumer accepts the row
//   next_address   last read address + 1 of the most recent complete row
module row_fetch
  import dcnn_pkg::*;
#(
  parameter int rowSize   = ROW_SIZE,
  parameter int blockSize = BLOCK_SIZE,
  parameter int addrWidth = ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [addrWidth-1:0] start_address,
  output logic                 busy,
  row_fetch_if.master          ram,
  output logic [rowSize-1:0]   row_out,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic [addrWidth-1:0] next_address
);

  localparam int N     = rowSize / blockSize;
  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if ((rowSize % blockSize) != 0 || N < 1) begin : g_bad_geometry
    $error("row_fetch: rowSize must be a positive multiple of blockSize");
  end

  fetch_state_e         state_q, state_d;
  logic [addrWidth-1:0] base_q, base_d;
  logic [CNT_W-1:0]     issue_q, issue_d;   // requests issued so far
  logic [CNT_W-1:0]     cap_q, cap_d;       // words captured so far
  logic                 ram_en_q, ram_en_d;
  logic [addrWidth-1:0] ram_addr_q, ram_addr_d;
  logic                 data_vld_q, data_vld_d;
  logic                 busy_q, busy_d;
  logic                 row_valid_q, row_valid_d;
  logic [addrWidth-1:0] next_addr_q, next_addr_d;
  logic                 load;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_d     = issue_q;
    cap_d       = cap_q;
    ram_en_d    = ram_en_q;
    ram_addr_d  = ram_addr_q;
    busy_d      = busy_q;
    row_valid_d = row_valid_q;
    next_addr_d = next_addr_q;
    // RAM answers one cycle after each request, so a returning word is
    // flagged by the previous cycle's request strobe.
    data_vld_d  = ram_en_q;
    load        = data_vld_q;

    if (data_vld_q) cap_d = cap_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // First request goes out together with the state change.
          base_d     = start_address;
          issue_d    = CNT_W'(1);
          cap_d      = '0;
          ram_en_d   = 1'b1;
          ram_addr_d = start_address;
          busy_d     = 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        if (issue_q == CNT_W'(N)) begin
          ram_en_d = 1'b0;
          state_d  = DRAIN;
        end else begin
          ram_addr_d = base_q + addrWidth'(issue_q);
          issue_d    = issue_q + 1'b1;
        end
      end
      DRAIN: begin
        if (data_vld_q && cap_q == CNT_W'(N - 1)) begin
          row_valid_d = 1'b1;
          next_addr_d = base_q + addrWidth'(N);
          state_d     = VALID;
        end
      end
      VALID: begin
        // A start arriving with row_ready is dropped: we only leave VALID here.
        if (row_ready) begin
          row_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_q     <= '0;
      cap_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      data_vld_q  <= 1'b0;
      busy_q      <= 1'b0;
      row_valid_q <= 1'b0;
      next_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_q     <= issue_d;
      cap_q       <= cap_d;
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      data_vld_q  <= data_vld_d;
      busy_q      <= busy_d;
      row_valid_q <= row_valid_d;
      next_addr_q <= next_addr_d;
    end
  end

  // Capture stage: returning word lands in the slot given by the capture count.
  row_pack_shift #(
    .blockSize (blockSize),
    .slots     (N),
    .idxWidth  (IDX_W)
  ) u_pack (
    .clk  (clk),
    .clr  (rst),
    .load (load),
    .idx  (cap_q[IDX_W-1:0]),
    .din  (ram.ram_data),
    .row  (row_out)
  );

  assign ram.ram_enable  = ram_en_q;
  assign ram.ram_write   = 1'b0;
  assign ram.ram_address = ram_addr_q;
  assign busy            = busy_q;
  assign row_valid       = row_valid_q;
  assign next_address    = next_addr_q;

endmodule
